// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_pkg
// Purpose : Shared types and defaults for the ADC sampling front end.
// Rev     : 1.0  initial release
// ============================================================================
package adc_pkg;

    localparam int c_ADC_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } adc_state_t;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/lock_sync.sv
`default_nettype none
// ============================================================================
// Module  : lock_sync
// Purpose : Two-flop synchroniser for an asynchronous PLL lock indication.
// Rev     : 1.0  initial release
// ============================================================================
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : lock_sync
`default_nettype wire

// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : adc_sample_ctrl
// Purpose : Lock-gated ADC capture, block averaging and single-entry
//           valid/ready output stage with sticky overrun flag.
// Rev     : 1.0  initial release
// ============================================================================
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int ADC_W         = c_ADC_W_DEFAULT,
    parameter int AVG_LOG2      = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             capture_en,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             locked,
    output logic             running,
    output logic             overrun
);

    localparam int c_ACC_W = ADC_W + AVG_LOG2;
    localparam int c_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE_CYCLES - 1);

    logic               w_locked;
    adc_state_t         r_state;
    adc_state_t         w_state_nxt;
    logic [c_SET_W-1:0] r_settle_cnt;
    logic               w_settle_done;
    logic               w_cap;

    logic [ADC_W-1:0]   r_smp;
    logic               r_smp_vld;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_ACC_W-1:0] w_sum;
    logic               w_blk_done;

    logic [ADC_W-1:0]   r_res;
    logic               r_res_vld;
    logic [ADC_W-1:0]   r_m_data;
    logic               r_m_valid;
    logic               r_overrun;
    logic               w_out_load;

    lock_sync u_lock_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (pll_lock),
        .o_sync  (w_locked)
    );

    assign w_settle_done = (r_settle_cnt == c_SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_locked) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!w_locked)          w_state_nxt = ST_WAIT_LOCK;
                else if (w_settle_done) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_locked) w_state_nxt = ST_WAIT_LOCK;
            end
            default: w_state_nxt = ST_WAIT_LOCK;
        endcase
    end

    // Counter only advances while settling with lock held; any other case parks it at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if ((r_state == ST_SETTLE) && w_locked && !w_settle_done) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end else begin
            r_settle_cnt <= '0;
        end
    end

    assign w_cap = (r_state == ST_RUN) && capture_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_smp     <= '0;
            r_smp_vld <= 1'b0;
        end else begin
            r_smp_vld <= w_cap;
            if (w_cap) r_smp <= adc_data;
        end
    end

    assign w_sum      = r_acc + c_ACC_W'(r_smp);
    assign w_blk_done = w_cap && r_smp_vld && (r_cnt == c_CNT_LAST);

    // Dropping w_cap discards a partial block, including a sample still in the input register.
    always_ff @(posedge clk) begin
        if (reset || !w_cap) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_smp_vld) begin
            if (r_cnt == c_CNT_LAST) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res     <= '0;
            r_res_vld <= 1'b0;
        end else begin
            r_res_vld <= w_blk_done;
            if (w_blk_done) r_res <= ADC_W'(w_sum >> AVG_LOG2);
        end
    end

    assign w_out_load = r_res_vld && (!r_m_valid || m_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_m_data  <= r_res;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (r_res_vld && !w_out_load) r_overrun <= 1'b1;
        end
    end

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign locked  = w_locked;
    assign running = (r_state == ST_RUN);
    assign overrun = r_overrun;

endmodule : adc_sample_ctrl
`default_nettype wire
